// File: rtl/cmd_encoder.sv
// DDR3 command encoder: turns command words into two-phase per-pin bit pairs for the
// command/address output SERDES, padding with NOP cycles according to a per-command spacing count.
module cmd_encoder #(
  parameter int ADDRESS_NUMBER = 15
) (
  input  logic                          clk_div,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_code,
  input  logic [ADDRESS_NUMBER-1:0]     cmd_addr,
  input  logic [2:0]                    cmd_bank,
  input  logic                          cmd_phase,
  input  logic [7:0]                    cmd_delay,
  input  logic                          cmd_last,
  input  logic                          cke_en,
  input  logic                          odt_en,
  input  logic                          tri_en,
  output logic [2*ADDRESS_NUMBER-1:0]   in_a,
  output logic [5:0]                    in_ba,
  output logic [1:0]                    in_we,
  output logic [1:0]                    in_ras,
  output logic [1:0]                    in_cas,
  output logic [1:0]                    in_cke,
  output logic [1:0]                    in_odt,
  output logic [1:0]                    in_tri,
  output logic                          seq_done,
  output logic                          busy
);

  logic [7:0]                  cnt_q, cnt_d;
  logic                        last_q, last_d;
  logic                        seq_done_q, seq_done_d;
  logic [2*ADDRESS_NUMBER-1:0] in_a_q, in_a_d;
  logic [5:0]                  in_ba_q, in_ba_d;
  logic [1:0]                  in_we_q, in_we_d;
  logic [1:0]                  in_ras_q, in_ras_d;
  logic [1:0]                  in_cas_q, in_cas_d;
  logic [1:0]                  in_cke_q, in_odt_q, in_tri_q;
  logic [2*ADDRESS_NUMBER-1:0] a_enc;
  logic [5:0]                  ba_enc;
  logic                        hs;

  // Address and bank are driven identically on both half-cycles of each pin.
  generate
    for (genvar gi = 0; gi < ADDRESS_NUMBER; gi++) begin : g_a
      assign a_enc[2*gi +: 2] = {2{cmd_addr[gi]}};
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_ba
      assign ba_enc[2*gi +: 2] = {2{cmd_bank[gi]}};
    end
  endgenerate

  assign cmd_ready = (cnt_q == 8'd0);
  assign busy      = (cnt_q != 8'd0);
  assign hs        = cmd_valid && cmd_ready;

  always_comb begin
    cnt_d      = cnt_q;
    last_d     = last_q;
    seq_done_d = 1'b0;
    in_a_d     = in_a_q;
    in_ba_d    = in_ba_q;
    in_ras_d   = 2'b11;
    in_cas_d   = 2'b11;
    in_we_d    = 2'b11;

    if (hs) begin
      cnt_d      = cmd_delay;
      // A zero-spaced last command completes immediately, so it never stays pending.
      last_d     = cmd_last && (cmd_delay != 8'd0);
      seq_done_d = cmd_last && (cmd_delay == 8'd0);
      in_a_d     = a_enc;
      in_ba_d    = ba_enc;
      in_ras_d[cmd_phase] = cmd_code[2];
      in_cas_d[cmd_phase] = cmd_code[1];
      in_we_d[cmd_phase]  = cmd_code[0];
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
      if (last_q && (cnt_q == 8'd1)) begin
        seq_done_d = 1'b1;
        last_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      last_q     <= 1'b0;
      seq_done_q <= 1'b0;
      in_a_q     <= '0;
      in_ba_q    <= 6'd0;
      in_ras_q   <= 2'b11;
      in_cas_q   <= 2'b11;
      in_we_q    <= 2'b11;
      in_cke_q   <= 2'b00;
      in_odt_q   <= 2'b00;
      in_tri_q   <= 2'b00;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      seq_done_q <= seq_done_d;
      in_a_q     <= in_a_d;
      in_ba_q    <= in_ba_d;
      in_ras_q   <= in_ras_d;
      in_cas_q   <= in_cas_d;
      in_we_q    <= in_we_d;
      in_cke_q   <= {2{cke_en}};
      in_odt_q   <= {2{odt_en}};
      in_tri_q   <= {2{tri_en}};
    end
  end

  assign in_a     = in_a_q;
  assign in_ba    = in_ba_q;
  assign in_ras   = in_ras_q;
  assign in_cas   = in_cas_q;
  assign in_we    = in_we_q;
  assign in_cke   = in_cke_q;
  assign in_odt   = in_odt_q;
  assign in_tri   = in_tri_q;
  assign seq_done = seq_done_q;

endmodule
